// File: rtl/vc_input_buffer_if.sv
// ---------------------------------------------------------------------------
// vc_input_buffer_if
//   Bundles the link-side write port, the arbiter-side read port and the
//   status/credit outputs of the virtual-channel input buffer.
//
//   Write side : flit_in, flit_valid, flit_vc
//   Read side  : rd_en, rd_vc (driven by the switch arbiter)
//   Status     : not_empty_0..3 (arbiter requests), vc_full[3:0]
//   Output     : flit_out, flit_out_valid, credit_valid, credit_vc
//   Errors     : overflow_err, underflow_err (sticky until reset)
//
//   master : the environment (link + arbiter) driving the buffer
//   slave  : the buffer itself
// ---------------------------------------------------------------------------
interface vc_input_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] flit_in;
    logic                  flit_valid;
    logic [1:0]            flit_vc;
    logic                  rd_en;
    logic [1:0]            rd_vc;

    logic                  not_empty_0;
    logic                  not_empty_1;
    logic                  not_empty_2;
    logic                  not_empty_3;
    logic [3:0]            vc_full;
    logic [DATA_WIDTH-1:0] flit_out;
    logic                  flit_out_valid;
    logic                  credit_valid;
    logic [1:0]            credit_vc;
    logic                  overflow_err;
    logic                  underflow_err;

    modport master (
        output flit_in, flit_valid, flit_vc, rd_en, rd_vc,
        input  not_empty_0, not_empty_1, not_empty_2, not_empty_3, vc_full,
        input  flit_out, flit_out_valid, credit_valid, credit_vc,
        input  overflow_err, underflow_err
    );

    modport slave (
        input  flit_in, flit_valid, flit_vc, rd_en, rd_vc,
        output not_empty_0, not_empty_1, not_empty_2, not_empty_3, vc_full,
        output flit_out, flit_out_valid, credit_valid, credit_vc,
        output overflow_err, underflow_err
    );
endinterface

// File: rtl/vc_input_buffer.sv
// ---------------------------------------------------------------------------
// vc_input_buffer
//   Router input buffer holding four independent circular FIFOs, one per
//   virtual channel. Flits arriving from the link are written into the FIFO
//   named by flit_vc; the arbiter reads one flit per cycle from the FIFO named
//   by rd_vc. Each accepted read produces the flit one cycle later together
//   with a credit pulse for the upstream router.
//
//   Parameters : DATA_WIDTH flit width, DEPTH per-VC depth (power of 2, >= 2)
//   Ports      : clk  - single clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - vc_input_buffer_if slave modport (see interface file)
//
//   All four FIFOs share one storage array addressed by {vc, pointer}, so a
//   single write port and a single registered read port suffice and the array
//   maps onto one block RAM. The storage is not reset; only pointers, counts
//   and output registers are.
// ---------------------------------------------------------------------------
module vc_input_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst,
    vc_input_buffer_if.slave    bus
);
    localparam int NUM_VC = 4;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ADDR_W = PTR_W + 2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Per-VC state exported from the generate loop for the shared muxes.
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [NUM_VC-1:0] wr_accept;
    logic [NUM_VC-1:0] rd_accept;
    logic [NUM_VC-1:0] vc_empty;
    logic [NUM_VC-1:0] vc_full_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] count_reg;
            logic [CNT_W-1:0] count_next;

            assign vc_empty[gi]  = (count_reg == '0);
            assign vc_full_w[gi] = (count_reg == FULL_CNT);

            // Acceptance looks only at the count before the edge: a read does
            // not free space for a same-edge write to a full VC, and a write
            // does not bypass into a same-edge read of an empty VC.
            assign wr_accept[gi] = bus.flit_valid && (bus.flit_vc == 2'(gi))
                                   && !vc_full_w[gi];
            assign rd_accept[gi] = bus.rd_en && (bus.rd_vc == 2'(gi))
                                   && !vc_empty[gi];

            always_comb begin
                count_next = count_reg;
                case ({wr_accept[gi], rd_accept[gi]})
                    2'b10:   count_next = count_reg + CNT_W'(1);
                    2'b01:   count_next = count_reg - CNT_W'(1);
                    default: count_next = count_reg;
                endcase
            end

            // DEPTH is a power of two, so natural pointer overflow is the
            // modulo-DEPTH wrap.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (wr_accept[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (rd_accept[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    count_reg <= count_next;
                end
            end

            assign wr_ptr[gi] = wr_ptr_reg;
            assign rd_ptr[gi] = rd_ptr_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Shared storage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [NUM_VC*DEPTH];
    logic                  wr_go;
    logic                  rd_go;
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     rd_addr;

    assign wr_go   = |wr_accept;
    assign rd_go   = |rd_accept;
    assign wr_addr = {bus.flit_vc, wr_ptr[bus.flit_vc]};
    assign rd_addr = {bus.rd_vc, rd_ptr[bus.rd_vc]};

    // An accepted read never targets the slot an accepted write is filling:
    // a non-empty, non-full VC has rd_ptr != wr_ptr, and a write to a full
    // VC is rejected, so no read-during-write handling is needed.
    always_ff @(posedge clk) begin
        if (!rst && wr_go) begin
            mem[wr_addr] <= bus.flit_in;
        end
    end

    // ------------------------------------------------------------------
    // Output, credit and error registers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] flit_out_reg;
    logic                  flit_out_valid_reg;
    logic                  credit_valid_reg;
    logic [1:0]            credit_vc_reg;
    logic                  overflow_err_reg;
    logic                  underflow_err_reg;
    logic                  overflow_hit;
    logic                  underflow_hit;

    assign overflow_hit  = bus.flit_valid && vc_full_w[bus.flit_vc];
    assign underflow_hit = bus.rd_en && vc_empty[bus.rd_vc];

    always_ff @(posedge clk) begin
        if (rst) begin
            flit_out_reg       <= '0;
            flit_out_valid_reg <= 1'b0;
            credit_valid_reg   <= 1'b0;
            credit_vc_reg      <= 2'd0;
            overflow_err_reg   <= 1'b0;
            underflow_err_reg  <= 1'b0;
        end else begin
            // flit_out only loads on an accepted read and otherwise holds.
            if (rd_go) begin
                flit_out_reg  <= mem[rd_addr];
                credit_vc_reg <= bus.rd_vc;
            end
            flit_out_valid_reg <= rd_go;
            credit_valid_reg   <= rd_go;
            overflow_err_reg   <= overflow_err_reg | overflow_hit;
            underflow_err_reg  <= underflow_err_reg | underflow_hit;
        end
    end

    assign bus.flit_out       = flit_out_reg;
    assign bus.flit_out_valid = flit_out_valid_reg;
    assign bus.credit_valid   = credit_valid_reg;
    assign bus.credit_vc      = credit_vc_reg;
    assign bus.overflow_err   = overflow_err_reg;
    assign bus.underflow_err  = underflow_err_reg;

    // Status flags come straight from the registered counts.
    assign bus.not_empty_0 = !vc_empty[0];
    assign bus.not_empty_1 = !vc_empty[1];
    assign bus.not_empty_2 = !vc_empty[2];
    assign bus.not_empty_3 = !vc_empty[3];
    assign bus.vc_full     = vc_full_w;
endmodule

// File: tb/tb_vc_input_buffer.sv
module tb_vc_input_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vc_input_buffer_if #(.DATA_WIDTH(DW)) bus ();

    vc_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: one queue per VC, plus a scoreboard of flits that
    // should appear on flit_out, in order.
    logic [31:0] mq [4][$];
    logic [33:0] sb [$];
    logic        exp_valid;
    logic [31:0] last_out;
    logic        exp_ovf;
    logic        exp_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: r=reset, wv/wvc/wd=write, re/rvc=read.
    task automatic step(input logic r, input logic wv, input logic [1:0] wvc,
                        input logic [31:0] wd, input logic re, input logic [1:0] rvc);
        logic        rd_ok;
        logic        wr_ok;
        logic [31:0] rdat;
        logic [33:0] e;
        logic [3:0]  ne;
        logic [3:0]  fl;
        rst            = r;
        bus.flit_valid = wv;
        bus.flit_vc    = wvc;
        bus.flit_in    = wd;
        bus.rd_en      = re;
        bus.rd_vc      = rvc;
        if (r) begin
            for (int v = 0; v < 4; v++) mq[v].delete();
            sb.delete();
            exp_valid = 1'b0;
            last_out  = '0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
        end else begin
            rd_ok = re && (mq[rvc].size() != 0);
            wr_ok = wv && (mq[wvc].size() < DEPTH);
            if (rd_ok) begin
                rdat = mq[rvc].pop_front();
                sb.push_back({rvc, rdat});
            end
            if (wr_ok) mq[wvc].push_back(wd);
            if (wv && !wr_ok) exp_ovf = 1'b1;
            if (re && !rd_ok) exp_unf = 1'b1;
            exp_valid = rd_ok;
        end

        @(posedge clk);
        #1;

        check("flit_out_valid", 32'(bus.flit_out_valid), 32'(exp_valid));
        check("credit_valid", 32'(bus.credit_valid), 32'(exp_valid));
        if (exp_valid && sb.size() != 0) begin
            e = sb.pop_front();
            last_out = e[31:0];
            check("flit_out", bus.flit_out, e[31:0]);
            check("credit_vc", 32'(bus.credit_vc), 32'(e[33:32]));
            $display("read vc%0d flit 0x%0h", bus.credit_vc, bus.flit_out);
        end else begin
            check("flit_out_hold", bus.flit_out, last_out);
        end
        for (int v = 0; v < 4; v++) begin
            ne[v] = (mq[v].size() != 0);
            fl[v] = (mq[v].size() == DEPTH);
        end
        check("not_empty", 32'({bus.not_empty_3, bus.not_empty_2, bus.not_empty_1, bus.not_empty_0}), 32'(ne));
        check("vc_full", 32'(bus.vc_full), 32'(fl));
        check("overflow_err", 32'(bus.overflow_err), 32'(exp_ovf));
        check("underflow_err", 32'(bus.underflow_err), 32'(exp_unf));
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Single flit through VC2
        step(0, 1, 2, 32'hA0, 0, 0);
        step(0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0);

        // Fill VC0, overflow, drain in order
        for (int i = 1; i <= 4; i++) step(0, 1, 0, 32'(i), 0, 0);
        step(0, 1, 0, 32'h5, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);

        // Wrap on VC1
        for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h11 + 32'(i), 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h14 + 32'(i), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0);

        // Simultaneous write/read on VC3 holding two flits
        step(0, 1, 3, 32'h31, 0, 0);
        step(0, 1, 3, 32'h32, 0, 0);
        step(0, 1, 3, 32'h55, 1, 3);
        // Read of empty VC0 while writing VC0: no bypass
        step(0, 1, 0, 32'h77, 1, 0);
        // Write and read of different VCs at the same edge
        step(0, 1, 2, 32'hB2, 1, 3);
        step(0, 0, 0, 0, 1, 3);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0);

        // Full VC read and written at same edge: write rejected
        for (int i = 0; i < 4; i++) step(0, 1, 2, 32'hC0 + 32'(i), 0, 0);
        step(0, 1, 2, 32'hCF, 1, 2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 2);

        // Reset mid-operation dominates requests and discards contents
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 0, 32'hD0 + 32'(i), 0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 1, 32'hE0 + 32'(i), 0, 0);
        step(1, 1, 0, 32'hDD, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the flit width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the per-VC FIFO depth in flits; it SHALL be a power of 2 and at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 flit_in  input  DATA_WIDTH  SHALL carry the incoming flit from the link.
REQ-006 flit_valid  input  1  SHALL qualify flit_in as a write request.
REQ-007 flit_vc  input  2  SHALL select the target VC (0-3) for the write.
REQ-008 rd_en  input  1  SHALL request a read; driven by the arbiter "selected" output.
REQ-009 rd_vc  input  2  SHALL select the VC to read; driven by the arbiter VC buffer-select output.
REQ-010 not_empty_0..not_empty_3  output  1 each  SHALL flag that the VC FIFO holds at least one flit; these feed the arbiter per-VC request inputs.
REQ-011 vc_full  output  4  SHALL flag each full VC FIFO; bit i is VC i.
REQ-012 flit_out  output  DATA_WIDTH  SHALL carry the flit read.
REQ-013 flit_out_valid  output  1  SHALL qualify flit_out.
REQ-014 credit_valid  output  1  SHALL pulse once per flit read, for upstream credit return.
REQ-015 credit_vc  output  2  SHALL give the VC of the returned credit.
REQ-016 overflow_err  output  1  SHALL be a sticky flag for a rejected write.
REQ-017 underflow_err  output  1  SHALL be a sticky flag for a rejected read.

Function
REQ-018 Storage SHALL be four independent circular FIFOs, each with DEPTH entries and its own read pointer, write pointer and count. Pointer width SHALL be log2(DEPTH); count width SHALL be log2(DEPTH)+1.
REQ-019 A write SHALL be accepted when flit_valid=1 and count[flit_vc] < DEPTH at the clock edge. On acceptance: store the flit at wr_ptr[flit_vc], increment wr_ptr[flit_vc] modulo DEPTH, increment count[flit_vc].
REQ-020 A read SHALL be accepted when rd_en=1 and count[rd_vc] > 0 at the clock edge. On acceptance: load flit_out from rd_ptr[rd_vc], increment rd_ptr[rd_vc] modulo DEPTH, decrement count[rd_vc].
REQ-021 Read latency SHALL be 1 cycle: an accepted read at edge N drives flit_out_valid=1 with the flit during cycle N+1.
REQ-022 flit_out_valid SHALL be 0 in any cycle that does not follow an accepted read; flit_out SHALL then hold its last value.
REQ-023 credit_valid SHALL be 1 in the same cycle as flit_out_valid, with credit_vc equal to the VC that was read.
REQ-024 not_empty_i SHALL equal (count[i] != 0), and vc_full[i] SHALL equal (count[i] == DEPTH). Both SHALL be combinational from the registered counts, with no extra delay.
REQ-025 Write and read to the same VC at the same edge SHALL both be accepted when the VC is neither empty nor full; count is then unchanged and both pointers advance.
REQ-026 A write to a full VC SHALL be rejected, even if the same VC is read at the same edge. Nothing is stored and overflow_err is set to 1.
REQ-027 A read from an empty VC SHALL be rejected, even if the same VC is written at the same edge; there is no bypass. The outputs follow REQ-022 and underflow_err is set to 1.
REQ-028 A write and a read to different VCs at the same edge SHALL proceed independently.
REQ-029 Pointer wrap-around from DEPTH-1 to 0 SHALL preserve FIFO order across the wrap.
REQ-030 overflow_err and underflow_err SHALL stay 1 until reset.

Reset
REQ-031 When rst=1 at a clock edge, all pointers and counts SHALL clear to 0.
REQ-032 At the same reset edge, flit_out, flit_out_valid, credit_valid, credit_vc, overflow_err and underflow_err SHALL clear to 0. As a result, all not_empty_i=0 and vc_full=4'b0000.
REQ-033 Reset SHALL dominate any write or read at the same edge. A reset mid-operation SHALL discard all stored flits.
REQ-034 Storage array contents need not be cleared by reset.

Verification
REQ-035 Reset, then write 0xA0 to VC2 -> next cycle not_empty_2=1 while the other not_empty flags are 0. Then rd_en=1 with rd_vc=2 -> one cycle later flit_out=0xA0, flit_out_valid=1, credit_valid=1, credit_vc=2; afterwards not_empty_2=0.
REQ-036 Write 4 flits 0x1..0x4 to VC0 -> vc_full=4'b0001. A 5th write of 0x5 -> rejected and overflow_err=1. Four reads -> flit_out returns 0x1, 0x2, 0x3, 0x4 in order.
REQ-037 Wrap test on VC1: write 3, read 2, write 3 (the pointers wrap) -> reads return all flits in write order and count ends at 0.
REQ-038 VC3 holds 2 flits; at one edge write 0x55 to VC3 and read VC3 -> count stays 2 and the oldest flit is output. Separately, a read of empty VC0 at the same edge as a write to VC0 -> read rejected, underflow_err=1, count[0]=1.
REQ-039 Fill VC0 and VC1 with 2 flits each, assert rst=1 for one cycle while a write to VC0 and a read of VC1 are requested -> after the edge all not_empty=0, vc_full=0, flit_out_valid=0, credit_valid=0, both error flags 0, and no flit is output.
